// File: rtl/noc_port_requester.sv
// noc_port_requester: requester end of the router output-arbitration handshake.
// Buffers incoming flits, XY-routes each packet from its head flit, holds a
// one-hot request to the selected output arbiter until the tail has been
// forwarded, then waits for the arbiter's registered grant to fall.
//
// Optional feature macro: PORT_DROP_CNT_EN adds a saturating drop counter.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/flit   upstream flit stream; in_ready = FIFO not full
//   req[4:0]        one-hot request {west, south, east, north, local}
//   gnt[4:0]        grants from the five output arbiters
//   out_valid/flit  forwarded flit (registered, one cycle after the pop)
//   drop_err        one-cycle pulse after a malformed front flit is discarded
//   drop_cnt[7:0]   saturating discard count (PORT_DROP_CNT_EN only)
module noc_port_requester #(
    parameter int unsigned FLIT_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter logic [3:0]  X_ID   = 4'd0,
    parameter logic [3:0]  Y_ID   = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic [4:0]        req,
    input  logic [4:0]        gnt,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic              drop_err
`ifdef PORT_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, SEND, RELEASE} state_t;

    state_t             state, state_next;
    logic [2:0]         port_r, port_next;
    logic [4:0]         req_next;
    logic               out_valid_next;
    logic [FLIT_W-1:0]  out_flit_next;
    logic               drop_next;
    logic               pop;
    logic               push;

    logic [FLIT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, empty;
    logic [FLIT_W-1:0]  front;
    logic [1:0]         front_type;
    logic               gnt_sel;
    logic               front_is_head;
    logic               front_is_last;

    // XY dimension-order routing: resolve X first, then Y, else local.
    function automatic logic [2:0] xy_route(input logic [7:0] dest);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [2:0] p;
        dx = dest[7:4];
        dy = dest[3:0];
        p  = 3'd0;
        if (dx > X_ID)      p = 3'd2;
        else if (dx < X_ID) p = 3'd4;
        else if (dy > Y_ID) p = 3'd1;
        else if (dy < Y_ID) p = 3'd3;
        return p;
    endfunction

    assign full          = (count == CNT_W'(DEPTH));
    assign empty         = (count == '0);
    assign in_ready      = !full;
    assign push          = in_valid && !full;
    assign front         = mem[rd_ptr];
    assign front_type    = front[FLIT_W-1 -: 2];
    assign front_is_head = (front_type == TYPE_HEAD) || (front_type == TYPE_SINGLE);
    assign front_is_last = (front_type == TYPE_TAIL) || (front_type == TYPE_SINGLE);
    assign gnt_sel       = gnt[port_r];

    // FIFO storage (no reset needed; validity tracked by count)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_flit;
    end

    // FIFO pointers and occupancy; pointers wrap naturally for power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            port_r    <= 3'd0;
            req       <= '0;
            out_valid <= 1'b0;
            out_flit  <= '0;
            drop_err  <= 1'b0;
        end else begin
            state     <= state_next;
            port_r    <= port_next;
            req       <= req_next;
            out_valid <= out_valid_next;
            out_flit  <= out_flit_next;
            drop_err  <= drop_next;
        end
    end

    // Next-state, pop control and next values of the registered outputs
    always_comb begin
        state_next     = state;
        port_next      = port_r;
        req_next       = req;
        pop            = 1'b0;
        out_valid_next = 1'b0;
        out_flit_next  = out_flit;
        drop_next      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (front_is_head) begin
                        port_next  = xy_route(front[7:0]);
                        req_next   = 5'b00001 << xy_route(front[7:0]);
                        state_next = REQ;
                    end else begin
                        pop       = 1'b1;
                        drop_next = 1'b1;
                    end
                end
            end
            REQ: begin
                if (gnt_sel) state_next = SEND;
            end
            SEND: begin
                // A head seen mid-packet is forwarded as ordinary payload.
                if (gnt_sel && !empty) begin
                    pop            = 1'b1;
                    out_valid_next = 1'b1;
                    out_flit_next  = front;
                    if (front_is_last) begin
                        req_next   = '0;
                        state_next = RELEASE;
                    end
                end
            end
            RELEASE: begin
                // Wait out the arbiter's registered grant before re-requesting.
                req_next = '0;
                if (!gnt_sel) state_next = IDLE;
            end
            default: begin
                req_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

`ifdef PORT_DROP_CNT_EN
    // Saturating count of discarded malformed flits
    always_ff @(posedge clk) begin
        if (rst)                                drop_cnt <= '0;
        else if (drop_next && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_noc_port_requester.sv
// Directed bench for noc_port_requester (X_ID=1, Y_ID=1, DEPTH=4).
module tb_noc_port_requester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_flit = '0;
    logic        in_ready;
    logic [4:0]  req;
    logic [4:0]  gnt;
    logic        out_valid;
    logic [15:0] out_flit;
    logic        drop_err;
`ifdef PORT_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    logic        echo_en = 1'b0;
    logic [4:0]  gnt_man = '0;
    logic [4:0]  req_d1 = '0;
    logic [4:0]  req_d2 = '0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] out_q[$];

    noc_port_requester #(
        .FLIT_W(16),
        .DEPTH (4),
        .X_ID  (4'd1),
        .Y_ID  (4'd1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_flit  (in_flit),
        .in_ready (in_ready),
        .req      (req),
        .gnt      (gnt),
        .out_valid(out_valid),
        .out_flit (out_flit),
        .drop_err (drop_err)
`ifdef PORT_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Arbiter stand-in: echo req with a two-cycle delay, or a manual grant
    always @(posedge clk) begin
        req_d1 <= req;
        req_d2 <= req_d1;
    end
    assign gnt = echo_en ? req_d2 : gnt_man;

    // Capture every forwarded flit
    always @(negedge clk) begin
        if (out_valid) out_q.push_back(out_flit);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [1:0] t, input logic [5:0] p,
                                       input logic [3:0] dx, input logic [3:0] dy);
        return {t, p, dx, dy};
    endfunction

    task automatic push_flit(input logic [15:0] f);
        in_valid = 1'b1;
        in_flit  = f;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        echo_en = 1'b0;
        gnt_man = '0;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        out_q.delete();
    endtask

    // Bounded wait for n captured flits and a fully released handshake
    task automatic wait_idle(input string tag, input int n);
        for (int i = 0; i < 40; i++) begin
            if (out_q.size() >= n && req == 5'd0 && gnt == 5'd0) break;
            tick();
        end
        check_eq(tag, 32'(out_q.size()), 32'(n));
        tick();
        tick();
    endtask

    logic [3:0]  dxs [5];
    logic [3:0]  dys [5];
    logic [4:0]  exp_req [5];
    logic [15:0] pkt [6];
    logic [15:0] f;
    int          k;
    int          seen;
    logic        acc;

    initial begin
        dxs     = '{4'd3, 4'd0, 4'd1, 4'd1, 4'd1};
        dys     = '{4'd1, 4'd1, 4'd2, 4'd0, 4'd1};
        exp_req = '{5'b00100, 5'b10000, 5'b00010, 5'b01000, 5'b00001};

        // Reset values
        tick();
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_req", 32'(req), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_flit", 32'(out_flit), 32'd0);
        check_eq("rst_drop_err", 32'(drop_err), 32'd0);
`ifdef PORT_DROP_CNT_EN
        check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        rst = 1'b0;
        tick();
        tick();

        // Route select with echoed grant
        echo_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            out_q.delete();
            f = mk(2'b11, 6'(i + 1), dxs[i], dys[i]);
            push_flit(f);
            check_eq($sformatf("route%0d_req_lat", i), 32'(req), 32'd0);
            tick();
            check_eq($sformatf("route%0d_req", i), 32'(req), 32'(exp_req[i]));
            wait_idle($sformatf("route%0d_cnt", i), 1);
            if (out_q.size() > 0)
                check_eq($sformatf("route%0d_flit", i), 32'(out_q[0]), 32'(f));
        end

        // Four-flit packet, back-to-back output
        do_reset();
        echo_en = 1'b1;
        pkt[0] = mk(2'b01, 6'h11, 4'd2, 4'd1);
        pkt[1] = mk(2'b00, 6'h12, 4'd5, 4'd5);
        pkt[2] = mk(2'b00, 6'h13, 4'd6, 4'd6);
        pkt[3] = mk(2'b10, 6'h14, 4'd7, 4'd7);
        for (int i = 0; i < 4; i++) push_flit(pkt[i]);
        tick();
        check_eq("pkt_pre_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("pkt_valid%0d", i), 32'(out_valid), 32'd1);
            check_eq($sformatf("pkt_flit%0d", i), 32'(out_flit), 32'(pkt[i]));
            check_eq($sformatf("pkt_req%0d", i), 32'(req), (i == 3) ? 32'd0 : 32'd4);
        end
        tick();
        check_eq("pkt_post_valid", 32'(out_valid), 32'd0);
        wait_idle("pkt_cnt", 4);

        // Stale grant between back-to-back single-flit packets
        do_reset();
        pkt[0] = mk(2'b11, 6'h21, 4'd3, 4'd1);
        pkt[1] = mk(2'b11, 6'h22, 4'd3, 4'd1);
        push_flit(pkt[0]);
        push_flit(pkt[1]);
        check_eq("stale_req_a", 32'(req), 32'd4);
        tick();
        tick();
        gnt_man = 5'b00100;
        tick();
        check_eq("stale_req_send", 32'(req), 32'd4);
        tick();
        check_eq("stale_req_fall", 32'(req), 32'd0);
        tick();
        check_eq("stale_req_hold1", 32'(req), 32'd0);
        tick();
        gnt_man = 5'b00000;
        check_eq("stale_req_hold2", 32'(req), 32'd0);
        tick();
        check_eq("stale_req_idle", 32'(req), 32'd0);
        tick();
        check_eq("stale_req_b", 32'(req), 32'd4);
        check_eq("stale_no_dup", 32'(out_q.size()), 32'd1);
        gnt_man = 5'b00100;
        for (int i = 0; i < 20; i++) begin
            if (req == 5'd0) break;
            tick();
        end
        tick();
        tick();
        gnt_man = 5'b00000;
        wait_idle("stale_cnt", 2);
        if (out_q.size() >= 2) begin
            check_eq("stale_flit_a", 32'(out_q[0]), 32'(pkt[0]));
            check_eq("stale_flit_b", 32'(out_q[1]), 32'(pkt[1]));
        end

        // Malformed front flits are discarded
        do_reset();
        push_flit(mk(2'b00, 6'h31, 4'd2, 4'd1));
        push_flit(mk(2'b10, 6'h32, 4'd2, 4'd1));
        check_eq("mal_drop1", 32'(drop_err), 32'd1);
        check_eq("mal_req1", 32'(req), 32'd0);
        tick();
        check_eq("mal_drop2", 32'(drop_err), 32'd1);
        tick();
        check_eq("mal_drop_end", 32'(drop_err), 32'd0);
        check_eq("mal_req2", 32'(req), 32'd0);
        check_eq("mal_no_out", 32'(out_q.size()), 32'd0);
`ifdef PORT_DROP_CNT_EN
        check_eq("mal_drop_cnt", 32'(drop_cnt), 32'd2);
`endif

        // Full FIFO backpressure, then drain in order
        do_reset();
        pkt[0] = mk(2'b01, 6'h01, 4'd2, 4'd1);
        pkt[1] = mk(2'b00, 6'h02, 4'd0, 4'd0);
        pkt[2] = mk(2'b00, 6'h03, 4'd0, 4'd0);
        pkt[3] = mk(2'b00, 6'h04, 4'd0, 4'd0);
        pkt[4] = mk(2'b00, 6'h05, 4'd0, 4'd0);
        pkt[5] = mk(2'b10, 6'h06, 4'd0, 4'd0);
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_flit  = pkt[k];
            acc      = in_ready;
            tick();
            if (acc) k++;
        end
        check_eq("full_accepted", 32'(k), 32'd4);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        check_eq("full_req", 32'(req), 32'd4);
        gnt_man = 5'b00100;
        for (int c = 0; c < 30 && k < 6; c++) begin
            in_valid = 1'b1;
            in_flit  = pkt[k];
            acc      = in_ready;
            tick();
            if (acc) k++;
        end
        in_valid = 1'b0;
        check_eq("full_all_pushed", 32'(k), 32'd6);
        for (int i = 0; i < 30; i++) begin
            if (out_q.size() >= 6) break;
            tick();
        end
        tick();
        gnt_man = 5'b00000;
        wait_idle("full_cnt", 6);
        for (int i = 0; i < 6; i++) begin
            if (i < out_q.size())
                check_eq($sformatf("full_flit%0d", i), 32'(out_q[i]), 32'(pkt[i]));
        end

        // Reset in the middle of a packet
        do_reset();
        pkt[0] = mk(2'b01, 6'h31, 4'd2, 4'd1);
        pkt[1] = mk(2'b00, 6'h32, 4'd0, 4'd0);
        pkt[2] = mk(2'b00, 6'h33, 4'd0, 4'd0);
        pkt[3] = mk(2'b10, 6'h34, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) push_flit(pkt[i]);
        gnt_man = 5'b00100;
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_eq("mid_seen", 32'(seen), 32'd2);
        rst = 1'b1;
        tick();
        check_eq("mid_req", 32'(req), 32'd0);
        check_eq("mid_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        gnt_man = 5'b00000;
        tick();
        tick();
        tick();
        out_q.delete();
        echo_en = 1'b1;
        f = mk(2'b11, 6'h3F, 4'd1, 4'd0);
        push_flit(f);
        check_eq("mid_new_lat", 32'(req), 32'd0);
        tick();
        check_eq("mid_new_req", 32'(req), 32'd8);
        wait_idle("mid_new_cnt", 1);
        if (out_q.size() > 0)
            check_eq("mid_new_flit", 32'(out_q[0]), 32'(f));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
